// File: rtl/sha2_pkg.sv
// Shared types, sigma rotate/shift amounts and helper functions for the
// SHA-2 message-schedule generator (SHA-224/256 and SHA-384/512).
package sha2_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_e;

    localparam int unsigned ROUND_W = 7;

    localparam int unsigned S256_S0_R0 = 7;
    localparam int unsigned S256_S0_R1 = 18;
    localparam int unsigned S256_S0_SH = 3;
    localparam int unsigned S256_S1_R0 = 17;
    localparam int unsigned S256_S1_R1 = 19;
    localparam int unsigned S256_S1_SH = 10;

    localparam int unsigned S512_S0_R0 = 1;
    localparam int unsigned S512_S0_R1 = 8;
    localparam int unsigned S512_S0_SH = 7;
    localparam int unsigned S512_S1_R0 = 19;
    localparam int unsigned S512_S1_R1 = 61;
    localparam int unsigned S512_S1_SH = 6;

    function automatic int unsigned rounds_for(input int unsigned width);
        return (width == 64) ? 80 : 64;
    endfunction

    // Rotate within the active word width; 32-bit words live in bits [31:0].
    function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned width,
                                         input int unsigned n);
        logic [31:0] lo;
        lo = x[31:0];
        if (width == 64) return (x >> n) | (x << (64 - n));
        return {32'h0, (lo >> n) | (lo << (32 - n))};
    endfunction

    function automatic logic [63:0] sigma0(input logic [63:0] x, input int unsigned width);
        if (width == 64)
            return rotr(x, 64, S512_S0_R0) ^ rotr(x, 64, S512_S0_R1) ^ (x >> S512_S0_SH);
        return rotr(x, 32, S256_S0_R0) ^ rotr(x, 32, S256_S0_R1) ^ {32'h0, x[31:0] >> S256_S0_SH};
    endfunction

    function automatic logic [63:0] sigma1(input logic [63:0] x, input int unsigned width);
        if (width == 64)
            return rotr(x, 64, S512_S1_R0) ^ rotr(x, 64, S512_S1_R1) ^ (x >> S512_S1_SH);
        return rotr(x, 32, S256_S1_R0) ^ rotr(x, 32, S256_S1_R1) ^ {32'h0, x[31:0] >> S256_S1_SH};
    endfunction

endpackage

// File: rtl/sha2_msg_schedule_if.sv
// Block-in / word-out bus of the SHA-2 message-schedule generator.
interface sha2_msg_schedule_if
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W = 32
);
    logic                    blk_valid;
    logic                    blk_ready;
    logic [16*WORD_W-1:0]    block;
    logic                    abort;
    logic                    stall;
    logic                    w_valid;
    logic [WORD_W-1:0]       w_out;
    logic [ROUND_W-1:0]      w_round;
    logic                    w_last;

    modport master (
        output blk_valid, block, abort, stall,
        input  blk_ready, w_valid, w_out, w_round, w_last
    );

    modport slave (
        input  blk_valid, block, abort, stall,
        output blk_ready, w_valid, w_out, w_round, w_last
    );
endinterface

// File: rtl/sha2_sched_expand.sv
// Combinational schedule expansion: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16].
module sha2_sched_expand
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic [WORD_W-1:0] w0,
    input  logic [WORD_W-1:0] w1,
    input  logic [WORD_W-1:0] w9,
    input  logic [WORD_W-1:0] w14,
    output logic [WORD_W-1:0] w_new_c
);
    logic [WORD_W-1:0] s0;
    logic [WORD_W-1:0] s1;

    always_comb begin
        s0      = WORD_W'(sigma0(64'(w1), WORD_W));
        s1      = WORD_W'(sigma1(64'(w14), WORD_W));
        w_new_c = s1 + w9 + s0 + w0;
    end
endmodule

// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule: loads a 16-word block and streams W[0..ROUNDS-1].
// Build option SHA2_SCHED_STALL_EN: when undefined, stall is ignored.
module sha2_msg_schedule
    import sha2_pkg::*;
#(
    parameter int unsigned WORD_W = 32
) (
    input  logic                 clk,
    input  logic                 Reset,
    sha2_msg_schedule_if.slave   bus
);
    localparam int unsigned ROUNDS = rounds_for(WORD_W);

    if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
        $error("sha2_msg_schedule: WORD_W must be 32 or 64");
    end

    sched_state_e        state_q, state_d;
    logic [WORD_W-1:0]   win_q [16];
    logic [ROUND_W-1:0]  round_q;
    logic [WORD_W-1:0]   w_new_c;
    logic                stall_eff;
    logic                last_c, ready_c, accept_c, advance_c;

`ifdef SHA2_SCHED_STALL_EN
    assign stall_eff = bus.stall;
`else
    logic unused_stall;
    assign unused_stall = bus.stall;
    assign stall_eff    = 1'b0;
`endif

    sha2_sched_expand #(.WORD_W(WORD_W)) u_expand (
        .w0      (win_q[0]),
        .w1      (win_q[1]),
        .w9      (win_q[9]),
        .w14     (win_q[14]),
        .w_new_c (w_new_c)
    );

    // State register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: abort dominates, reload on last word beats dropping to IDLE
    always_comb begin
        state_d = state_q;
        if (bus.abort)                state_d = IDLE;
        else if (accept_c)            state_d = RUN;
        else if (advance_c && last_c) state_d = IDLE;
    end

    // Handshake decode and outputs
    always_comb begin
        last_c        = (state_q == RUN) && (round_q == ROUND_W'(ROUNDS - 1));
        ready_c       = !bus.abort && ((state_q == IDLE) || (last_c && !stall_eff));
        accept_c      = bus.blk_valid && ready_c;
        advance_c     = (state_q == RUN) && !stall_eff && !bus.abort;
        bus.blk_ready = ready_c;
        bus.w_valid   = (state_q == RUN);
        bus.w_last    = last_c;
        bus.w_out     = win_q[0];
        bus.w_round   = round_q;
    end

    // Window and round counter; the final advance holds so idle outputs stay put
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) win_q[i] <= '0;
            round_q <= '0;
        end else if (bus.abort) begin
            round_q <= '0;
        end else if (accept_c) begin
            for (int i = 0; i < 16; i++) win_q[i] <= bus.block[i*WORD_W +: WORD_W];
            round_q <= '0;
        end else if (advance_c && !last_c) begin
            for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
            win_q[15] <= w_new_c;
            round_q   <= round_q + ROUND_W'(1);
        end
    end
endmodule
